// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and sizes for the encoder line scheduler
//
// Purpose: line width, address width, memory depth, the scheduler state
// encoding and the line type used by the scheduler, its interface and its
// round counter.
package encoder_pkg;

  localparam int W      = 25;  // one 5x5 matrix line
  localparam int ADDR_W = 6;   // line memory address width
  localparam int LINES  = 64;  // memory depth, also the longest job

  typedef logic [W-1:0] enc_line_t;

  typedef enum logic [2:0] {
    ENC_IDLE  = 3'd0,
    ENC_READ  = 3'd1,
    ENC_LOAD  = 3'd2,
    ENC_PERM  = 3'd3,
    ENC_WRITE = 3'd4,
    ENC_DONE  = 3'd5
  } enc_state_t;

endpackage

// File: rtl/encoder_scheduler_if.sv
// rtl/encoder_scheduler_if.sv - line memory read port and result write port
//
// Purpose: bundles the memory-side signals of the scheduler.
// Ports:
//   rd_en, rd_addr  read strobe and address (scheduler -> memory)
//   rd_data         read data, valid the cycle after rd_en (memory -> scheduler)
//   wr_valid        write request (scheduler -> memory)
//   wr_ready        write accept (memory -> scheduler)
//   wr_addr,wr_data write address and result line (scheduler -> memory)
// Modports: master = scheduler side, slave = memory side.
interface encoder_scheduler_if;

  logic                               rd_en;
  logic [encoder_pkg::ADDR_W-1:0]     rd_addr;
  encoder_pkg::enc_line_t             rd_data;
  logic                               wr_valid;
  logic                               wr_ready;
  logic [encoder_pkg::ADDR_W-1:0]     wr_addr;
  encoder_pkg::enc_line_t             wr_data;

  modport master (
    output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_data, wr_ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_data, wr_ready
  );

endinterface

// File: rtl/enc_round_counter.sv
// rtl/enc_round_counter.sv - saturating up-counter with clear, enable and terminal flag
//
// Purpose: counts from 0 up to a terminal value and holds there; never wraps.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       synchronous clear to 0 (wins over en)
//   en        count enable, ignored once the terminal value is reached
//   last      terminal value
//   count     current value
//   tc        high while count == last
module enc_round_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/encoder_scheduler.sv
// rtl/encoder_scheduler.sv - per-line read / permute / write-back job sequencer
//
// Purpose: on start, walks lines 0..len-1 of the line memory; each line is
// read, passed ROUNDS times through the external permutation block and
// written back to the same address over a valid/ready port.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       job request, sampled in IDLE only
//   num_lines   job length, clamped to LINES and latched on accepted start
//   busy        high from the cycle after an accepted start through DONE
//   done        one-cycle pulse at job end
//   perm_in     working register, feeds the permutation block
//   perm_out    combinational permutation of perm_in
//   mem         memory read/write port (master side)
module encoder_scheduler
  import encoder_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     num_lines,
  output logic                busy,
  output logic                done,
  output enc_line_t           perm_in,
  input  enc_line_t           perm_out,
  encoder_scheduler_if.master mem
);

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(LINES);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  enc_state_t        state;
  enc_line_t         work;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] line;
  logic [ADDR_W-1:0] line_last;
  // Only the terminal flag of the round counter steers the FSM.
  logic [RND_W-1:0]  rnd_unused;
  logic              line_tc;
  logic              rnd_tc;
  logic              accept;
  logic              rd_en_q;
  logic              wr_valid_q;

  assign accept      = (state == ENC_IDLE) && start;
  assign len_clamped = (num_lines > LEN_MAX) ? LEN_MAX : num_lines;
  // len is never 0 while the line counter matters, so len-1 fits ADDR_W bits.
  assign line_last   = ADDR_W'(len - LEN_ONE);

  enc_round_counter #(
    .WIDTH (ADDR_W)
  ) u_line_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    ((state == ENC_WRITE) && mem.wr_ready),
    .last  (line_last),
    .count (line),
    .tc    (line_tc)
  );

  enc_round_counter #(
    .WIDTH (RND_W)
  ) u_rnd_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept || (state == ENC_LOAD)),
    .en    (state == ENC_PERM),
    .last  (RND_LAST),
    .count (rnd_unused),
    .tc    (rnd_tc)
  );

  // Strobes are set on the edge that enters their state so they are
  // registered outputs aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENC_IDLE;
      work       <= '0;
      len        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_en_q <= 1'b0;
      case (state)
        ENC_IDLE: begin
          if (start) begin
            len  <= len_clamped;
            busy <= 1'b1;
            if (len_clamped == '0) begin
              state <= ENC_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ENC_READ;
              rd_en_q <= 1'b1;
            end
          end
        end
        ENC_READ: begin
          state <= ENC_LOAD;
        end
        ENC_LOAD: begin
          work  <= mem.rd_data;
          state <= ENC_PERM;
        end
        ENC_PERM: begin
          work <= perm_out;
          if (rnd_tc) begin
            state      <= ENC_WRITE;
            wr_valid_q <= 1'b1;
          end
        end
        ENC_WRITE: begin
          if (mem.wr_ready) begin
            wr_valid_q <= 1'b0;
            if (line_tc) begin
              state <= ENC_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ENC_READ;
              rd_en_q <= 1'b1;
            end
          end
        end
        ENC_DONE: begin
          state <= ENC_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= ENC_IDLE;
          busy       <= 1'b0;
          wr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // work and line only change when not writing, so wr_addr/wr_data hold
  // steady under backpressure.
  assign perm_in      = work;
  assign mem.rd_en    = rd_en_q;
  assign mem.rd_addr  = line;
  assign mem.wr_valid = wr_valid_q;
  assign mem.wr_addr  = line;
  assign mem.wr_data  = work;

endmodule

// File: tb/tb_encoder_scheduler.sv
// tb/tb_encoder_scheduler.sv - scoreboard bench for encoder_scheduler
module tb_encoder_scheduler;
  import encoder_pkg::*;

  localparam int ROUNDS   = 4;
  localparam int LINE_CYC = 3 + ROUNDS;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    enc_line_t         d;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [ADDR_W:0] num_lines = '0;
  logic            busy;
  logic            done;
  enc_line_t       perm_in;
  enc_line_t       perm_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  wr_t wq[$];
  int  dq[$];

  encoder_scheduler_if mif();

  encoder_scheduler #(
    .ROUNDS (ROUNDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_lines (num_lines),
    .busy      (busy),
    .done      (done),
    .perm_in   (perm_in),
    .perm_out  (perm_out),
    .mem       (mif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bench permutation: rotate left by one.
  assign perm_out = {perm_in[W-2:0], perm_in[W-1]};

  // Line memory: line i holds i, registered read.
  always @(posedge clk) begin
    if (rst) mif.rd_data <= '0;
    else if (mif.rd_en) mif.rd_data <= enc_line_t'(mif.rd_addr);
  end

  function automatic enc_line_t exp_line(input int i);
    enc_line_t x;
    x = enc_line_t'(i);
    for (int r = 0; r < ROUNDS; r++) x = {x[W-2:0], x[W-1]};
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected writes and done cycles as the DUT presents them.
  // The cycle right after edge k is numbered k+1 here.
  always @(negedge clk) begin
    wr_t e;
    int  de;
    if (!rst && mif.wr_valid && mif.wr_ready) begin
      if (wq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %0h, required no write",
                 mif.wr_addr, mif.wr_data);
      end else begin
        e = wq.pop_front();
        check("wr_addr", 32'(mif.wr_addr), 32'(e.a));
        check("wr_data", 32'(mif.wr_data), 32'(e.d));
      end
    end
    if (!rst && done) begin
      if (dq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc + 1);
      end else begin
        de = dq.pop_front();
        check("done_cycle", 32'(cyc + 1), 32'(de));
      end
    end
  end

  task automatic push_writes(input int first, input int cnt);
    for (int i = first; i < first + cnt; i++) wq.push_back('{a: ADDR_W'(i), d: exp_line(i)});
  endtask

  task automatic do_start(input int n, input bit expect_done, input int extra);
    int eff;
    eff = (n > LINES) ? LINES : n;
    @(posedge clk); #1;
    start = 1'b1;
    num_lines = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_lines = (ADDR_W+1)'(5);  // late change, must be ignored
    // cyc now equals the index of the accepting edge
    if (expect_done) dq.push_back(cyc + eff * LINE_CYC + 1 + extra);
  endtask

  task automatic wait_done(input int budget, input bit hold_start,
                           output int n_idle, output int n_rd, output int n_wr);
    bit seen;
    seen = 1'b0;
    n_idle = 0; n_rd = 0; n_wr = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (!busy) n_idle++;
      if (mif.rd_en) n_rd++;
      if (mif.wr_valid) n_wr++;
      if (done) seen = 1'b1;
      else if (hold_start) start = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
    end
    if (hold_start) begin
      // start stays high through the done cycle, drops for the next IDLE
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic idle_watch(input int cycles, output int n_act);
    n_act = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (mif.rd_en || mif.wr_valid || done || busy) n_act++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_rd_en"},    32'(mif.rd_en), 32'd0);
    check({tag, "_wr_valid"}, 32'(mif.wr_valid), 32'd0);
    check({tag, "_rd_addr"},  32'(mif.rd_addr), 32'd0);
    check({tag, "_wr_addr"},  32'(mif.wr_addr), 32'd0);
    check({tag, "_wr_data"},  32'(mif.wr_data), 32'd0);
    check({tag, "_perm_in"},  32'(perm_in), 32'd0);
  endtask

  enc_line_t four_exp [4] = '{25'h0, 25'h10, 25'h20, 25'h30};

  initial begin
    int  n_idle, n_rd, n_wr, n_act;
    bit  found;
    mif.wr_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single line
    push_writes(0, 1);
    do_start(1, 1'b1, 0);
    wait_done(50, 1'b0, n_idle, n_rd, n_wr);
    check("single_writes", 32'(n_wr), 32'd1);

    // Four lines, busy throughout
    for (int i = 0; i < 4; i++) wq.push_back('{a: ADDR_W'(i), d: four_exp[i]});
    do_start(4, 1'b1, 0);
    wait_done(100, 1'b0, n_idle, n_rd, n_wr);
    check("four_busy_low_cycles", 32'(n_idle), 32'd0);
    check("four_writes", 32'(n_wr), 32'd4);
    check("four_reads", 32'(n_rd), 32'd4);

    // Write backpressure: three wr_ready-low cycles on line 2
    for (int i = 0; i < 4; i++) wq.push_back('{a: ADDR_W'(i), d: four_exp[i]});
    do_start(4, 1'b1, 3);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (mif.rd_en && mif.rd_addr == ADDR_W'(2)) found = 1'b1;
    end
    check("bp_read_line2_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    mif.wr_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (mif.wr_valid) found = 1'b1;
    end
    check("bp_write_seen", 32'(found), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_wr_valid", 32'(mif.wr_valid), 32'd1);
      check("bp_hold_wr_addr", 32'(mif.wr_addr), 32'd2);
      check("bp_hold_wr_data", 32'(mif.wr_data), 32'h20);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    mif.wr_ready = 1'b1;
    wait_done(60, 1'b0, n_idle, n_rd, n_wr);

    // Zero-length job
    do_start(0, 1'b1, 0);
    wait_done(10, 1'b0, n_idle, n_rd, n_wr);
    check("zero_rd_en", 32'(n_rd), 32'd0);
    check("zero_wr_valid", 32'(n_wr), 32'd0);

    // Oversized job clamps to LINES
    push_writes(0, LINES);
    do_start(100, 1'b1, 0);
    wait_done(600, 1'b0, n_idle, n_rd, n_wr);
    check("clamp_writes", 32'(n_wr), 32'(LINES));

    // Reset during PERM of line 1
    push_writes(0, 1);
    do_start(2, 1'b0, 0);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (mif.rd_en && mif.rd_addr == ADDR_W'(1)) found = 1'b1;
    end
    check("rst_read_line1_seen", 32'(found), 32'd1);
    @(posedge clk); #1;  // LOAD
    @(posedge clk); #1;  // first PERM
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    idle_watch(20, n_act);
    check("midrst_quiet", 32'(n_act), 32'd0);
    push_writes(0, 2);
    do_start(2, 1'b1, 0);
    wait_done(50, 1'b0, n_idle, n_rd, n_wr);
    check("after_rst_writes", 32'(n_wr), 32'd2);

    // start held every cycle during a 2-line job
    push_writes(0, 2);
    do_start(2, 1'b1, 0);
    wait_done(50, 1'b1, n_idle, n_rd, n_wr);
    check("busy_start_writes", 32'(n_wr), 32'd2);
    check("busy_start_busy_low", 32'(n_idle), 32'd0);
    idle_watch(20, n_act);
    check("busy_start_no_restart", 32'(n_act), 32'd0);

    check("writes_outstanding", 32'(wq.size()), 32'd0);
    check("dones_outstanding", 32'(dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/encoder_scheduler.md
# encoder_scheduler

Sequencer that drives one 25-bit 5x5 matrix line at a time through the encoder permutation datapath. Per line it reads from a 64-entry line memory, applies the permutation stage `ROUNDS` times, and writes the result back through a ready/valid write port. It sits between the line memory and the combinational permutation block, replacing testbench-driven sequencing with a start/done job interface.

## Interface
- `W`, 25: line width (5x5 bits)
- `ADDR_W`, 6: line address width
- `LINES`, 64: memory depth; maximum job length
- `ROUNDS`, 4: permutation applications per line, ≥1
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  job request, sampled in IDLE only
- `num_lines`  in  ADDR_W+1  job length, latched on accepted start
- `busy`  out  1  high from cycle after accepted start until DONE inclusive
- `done`  out  1  one-cycle pulse at job end
- `rd_en`  out  1  memory read strobe
- `rd_addr`  out  ADDR_W  read address
- `rd_data`  in  W  read data, valid the cycle after `rd_en`
- `perm_in`  out  W  working register, drives permutation block
- `perm_out`  in  W  combinational permutation result of `perm_in`
- `wr_valid`  out  1  write request
- `wr_ready`  in  1  write accept
- `wr_addr`  out  ADDR_W  write address (= source line)
- `wr_data`  out  W  result line

## Operation
- States: IDLE, READ, LOAD, PERM, WRITE, DONE.
- IDLE: on `start`, latch `min(num_lines, LINES)` into `len`, clear line counter `line` and round counter `rnd`. If `len`==0, go to DONE, else go to READ.
- READ: `rd_en`=1, `rd_addr`=`line`; go to LOAD.
- LOAD: `work`<=`rd_data`, `rnd`<=0; go to PERM.
- PERM: `work`<=`perm_out`, `rnd`<=`rnd`+1; leave for WRITE when `rnd`==ROUNDS-1.
- WRITE: `wr_valid`=1, `wr_addr`=`line`, `wr_data`=`work`. On `wr_ready`: if `line`==`len`-1, go to DONE; else `line`+1 and go to READ.
- DONE: `done`=1 for one cycle; go to IDLE.
- `perm_in`=`work` at all times.
- `start` outside IDLE is ignored. `num_lines` changes after latch have no effect.
- `wr_addr`/`wr_data` stay stable while `wr_valid` && !`wr_ready`. `wr_ready` outside WRITE is ignored.
- Counters are unsigned and never wrap: `line` ≤ LINES-1, `rnd` ≤ ROUNDS-1.

## Timing
- Reset: state IDLE; `work`, `line`, `rnd`, `len` are 0. All outputs are 0: `busy`, `done`, `rd_en`, `wr_valid`, `rd_addr`, `wr_addr`, `wr_data`, `perm_in`.
- `rst` mid-job: IDLE at the next edge. No further reads or writes, no `done` pulse.
- Accepted start at edge t: READ during cycle t+1.
- Per line, with `wr_ready` held high: 3+ROUNDS cycles (READ, LOAD, ROUNDS×PERM, WRITE). Each `wr_ready`-low cycle adds one.
- Job of N lines, `wr_ready` high: `done` asserted N·(3+ROUNDS)+1 cycles after the accepting edge.
- `start` in the `done` cycle is ignored. `start` held into the following IDLE cycle starts a new job.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Structure
- Shared package `encoder_pkg`: `W`, `ADDR_W`, `LINES`, state enum `enc_state_t`, line typedef `enc_line_t`.
- One sub-module, `enc_round_counter`: parameterised up-counter with synchronous clear, enable and terminal-count flag. Instantiated twice, for `line` (terminal at `len`-1) and `rnd` (terminal at ROUNDS-1).
- Permutation logic stays outside this block.

## Test plan
Bench setup: memory holds line i = i; bench permutation is rotate-left by 1; ROUNDS=4.
- **Single line.** `num_lines`=1, `start` pulse → one write, addr 0, data 0. `done` 8 cycles after start.
- **Four lines.** `num_lines`=4, `wr_ready`=1 → writes addr 0..3 with data 25'h0, 25'h10, 25'h20, 25'h30. `done` at cycle 29. `busy` high throughout.
- **Write backpressure.** Same job, `wr_ready` low 3 cycles on line 2 → `wr_data`=25'h20 and `wr_addr`=2 held stable. `done` at cycle 32.
- **Edge lengths.** `num_lines`=0 → `done` the cycle after start, no `rd_en`/`wr_valid`. `num_lines`=100 → exactly 64 writes, last at addr 63.
- **Reset mid-job.** `rst` during PERM of line 1 → next cycle all outputs 0, no `done`. A new start then processes from line 0.
- **Start while busy.** `start` pulsed every cycle during a 2-line job → no restart, exactly 2 writes, one `done`.
